dif_cmd_filter: RTL

Parametrised successor to the single-bit register / 4-bit code decoder used on the ECAL DIF front end. Synchronises N_CH asynchronous data lines and accepts a W-bit command code only after it has been stable for STABLE consecutive clocks. It then emits each newly accepted, range-checked code as a one-cycle valid pulse. Sits between the DIF board inputs and the DIF control logic.

---
 rtl/dif_pkg.sv | 25 ++
 rtl/dif_sync2.sv | 35 +++
 rtl/dif_cmd_filter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dif_pkg.sv
// Shared definitions for the DIF command filter.
//   state_e      : command filter FSM states (IDLE, COUNT, FIRE)
//   DEF_MAX_CODE : default highest legal command code
//   clog2()      : ceiling log2 used to size the stability counter
package dif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } state_e;

  localparam int DEF_MAX_CODE = 2;

  // Smallest r with 2**r >= v; returns at least 1 so a counter is never 0 bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dif_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs.
//   clk : sampling clock
//   rst : synchronous, active-high; clears both stages
//   d   : asynchronous input, WIDTH bits
//   q   : synchronised output, two clocks behind d
module dif_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dif_cmd_filter.sv
// DIF front-end input conditioning: synchronises N_CH data lines and filters a
// W-bit command code, accepting it only after STABLE consecutive identical
// samples and emitting each newly accepted code as a one-cycle pulse.
//   Clk       : system clock, all logic on rising edge
//   Rst       : synchronous, active-high reset
//   Din/Dout  : asynchronous data lines in, synchronised copy out (2 clocks)
//   Cmd_In    : asynchronous command code (0 = idle)
//   Cmd_Out   : accepted legal code (held when HOLD=1, pulsed when HOLD=0)
//   Cmd_Valid : one-cycle pulse when a new nonzero code is accepted
//   Cmd_Err   : one-cycle pulse with Cmd_Valid when that code exceeds MAX_CODE
//   dbg_state : current filter FSM state
// Handshake: Cmd_Valid is a registered strobe with no ready; the consumer must
// take Cmd_Out/Cmd_Err in the same cycle Cmd_Valid is high.
module dif_cmd_filter
  import dif_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 4,
  parameter int STABLE   = 3,
  parameter int MAX_CODE = DEF_MAX_CODE,
  parameter int HOLD     = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N_CH-1:0] Din,
  output logic [N_CH-1:0] Dout,
  input  logic [W-1:0]    Cmd_In,
  output logic [W-1:0]    Cmd_Out,
  output logic            Cmd_Valid,
  output logic            Cmd_Err,
  output state_e          dbg_state
);

  localparam int               CNT_W    = clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
  localparam logic [W-1:0]     MAX_C    = W'(MAX_CODE);

  logic [W-1:0] cmd_s;

  dif_sync2 #(.WIDTH(N_CH)) u_din_sync (
    .clk (Clk),
    .rst (Rst),
    .d   (Din),
    .q   (Dout)
  );

  dif_sync2 #(.WIDTH(W)) u_cmd_sync (
    .clk (Clk),
    .rst (Rst),
    .d   (Cmd_In),
    .q   (cmd_s)
  );

  state_e           state_q, state_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    out_d   = (HOLD != 0) ? out_q : '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_s != cand_q) begin
          cand_d  = cmd_s;
          cnt_d   = CNT_W'(1);
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Once the count is full the candidate is committed regardless of the
        // sample on this edge; a code stable for STABLE samples is accepted.
        if (cnt_q == STABLE_C) begin
          state_d = (cand_q != acc_q) ? ST_FIRE : ST_IDLE;
        end else if (cmd_s != cand_q) begin
          cand_d = cmd_s;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIRE: begin
        acc_d = cand_q;
        // Code 0 is the silent return to idle: it re-arms without a pulse.
        if (cand_q != '0) begin
          valid_d = 1'b1;
          if (cand_q > MAX_C) err_d = 1'b1;
          else                out_d = cand_q;
        end
        if (cmd_s != cand_q) begin
          cand_d  = cmd_s;
          cnt_d   = CNT_W'(1);
          state_d = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Cmd_Out   = out_q;
  assign Cmd_Valid = valid_q;
  assign Cmd_Err   = err_q;
  assign dbg_state = state_q;

endmodule
